// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control path.
package cpu_pkg;

  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned IMM_W     = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned LAT_W     = 2;
  localparam int unsigned RETIRED_W = 16;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and the rest of the core.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic                 run;
  logic                 step;
  logic [OPCODE_W-1:0]  opcode;
  logic                 dec_reg_write;
  logic                 dec_mem_write;
  logic                 dec_mem_to_reg;
  // Debug preload of the retired counter.
  logic                 retired_load;
  logic [RETIRED_W-1:0] retired_value;

  logic                 ir_load;
  logic                 pc_en;
  logic                 reg_write;
  logic                 mem_write;
  logic                 halted;
  logic                 busy;
  logic [STATE_W-1:0]   state;
  logic [RETIRED_W-1:0] retired;

  modport slave (
    input  run, step, opcode, dec_reg_write, dec_mem_write, dec_mem_to_reg,
           retired_load, retired_value,
    output ir_load, pc_en, reg_write, mem_write, halted, busy, state, retired
  );

  modport master (
    output run, step, opcode, dec_reg_write, dec_mem_write, dec_mem_to_reg,
           retired_load, retired_value,
    input  ir_load, pc_en, reg_write, mem_write, halted, busy, state, retired
  );

endinterface

// File: rtl/cpu_sequencer_latency_counter.sv
// Loadable down-counter; last is high when the count has reached zero.
module latency_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [LAT_W-1:0] load_val,
  output logic             last
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: turns decoder strobes into one-shot pulses and
// adds run/step/halt control plus a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int unsigned         IMEM_LAT    = 1,
  parameter int unsigned         DMEM_LAT    = 1
) (
  input  logic           clk,
  input  logic           rst,
  cpu_sequencer_if.slave bus
);

  localparam logic [LAT_W-1:0] IMEM_LOAD = LAT_W'(IMEM_LAT - 1);
  localparam logic [LAT_W-1:0] DMEM_LOAD = LAT_W'(DMEM_LAT - 1);

  state_e               state_q, state_d;
  logic                 single_q, single_d;
  logic [RETIRED_W-1:0] retired_q, retired_d;

  logic             lat_load;
  logic             lat_en;
  logic [LAT_W-1:0] lat_val;
  logic             lat_last;

  latency_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .en       (lat_en),
    .load_val (lat_val),
    .last     (lat_last)
  );

  always_comb begin
    state_d   = state_q;
    single_d  = single_q;
    retired_d = retired_q;
    lat_load  = 1'b0;
    lat_en    = 1'b0;
    lat_val   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d  = S_FETCH;
          single_d = 1'b0;
          lat_load = 1'b1;
          lat_val  = IMEM_LOAD;
        end else if (bus.step) begin
          state_d  = S_FETCH;
          single_d = 1'b1;
          lat_load = 1'b1;
          lat_val  = IMEM_LOAD;
        end
      end
      S_FETCH: begin
        lat_en = 1'b1;
        if (lat_last) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (bus.opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (bus.dec_mem_write || bus.dec_mem_to_reg) begin
          state_d  = S_MEMORY;
          lat_load = 1'b1;
          lat_val  = DMEM_LOAD;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        lat_en = 1'b1;
        if (lat_last) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        retired_d = retired_q + RETIRED_W'(1);
        if (bus.run && !single_q) begin
          state_d  = S_FETCH;
          lat_load = 1'b1;
          lat_val  = IMEM_LOAD;
        end else begin
          state_d  = S_IDLE;
          single_d = 1'b0;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d  = S_IDLE;
        single_d = 1'b0;
      end
    endcase

    if (bus.retired_load) retired_d = bus.retired_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      single_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      single_q  <= single_d;
      retired_q <= retired_d;
    end
  end

  // Write strobes derive only from the registered state, so an async reset kills them at once.
  assign bus.ir_load   = (state_q == S_FETCH) && lat_last;
  assign bus.pc_en     = (state_q == S_WRITEBACK);
  assign bus.reg_write = (state_q == S_WRITEBACK) && bus.dec_reg_write;
  assign bus.mem_write = (state_q == S_MEMORY) && lat_last && bus.dec_mem_write;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;

endmodule
